pcseq_call_ret: RTL

Program-counter sequencer with subroutine CALL/RET support, placed directly upstream of the CPU's hardware return-address stack. It owns the PC register. On CALL it pushes the return address into the stack and jumps. On RET it pops the stack, waits one cycle for the stack's registered output, then loads the PC. It also handles plain increment and jump, and detects stack overflow/underflow.

---
 rtl/pcseq_pkg.sv | 30 +++
 rtl/pcseq_call_ret.sv | 124 ++++++++++++
 2 files changed

// File: rtl/pcseq_pkg.sv
// Shared types for the PC sequencer: FSM states, default PC width and the
// request priority decode (call > ret > jump > inc).
package pcseq_pkg;

  localparam int PCSEQ_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RET_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    REQ_NONE = 3'd0,
    REQ_INC  = 3'd1,
    REQ_JUMP = 3'd2,
    REQ_RET  = 3'd3,
    REQ_CALL = 3'd4
  } req_e;

  function automatic req_e req_decode(input logic call, input logic ret,
                                      input logic jump, input logic inc);
    if (call)      return REQ_CALL;
    else if (ret)  return REQ_RET;
    else if (jump) return REQ_JUMP;
    else if (inc)  return REQ_INC;
    else           return REQ_NONE;
  endfunction

endpackage

// File: rtl/pcseq_call_ret.sv
// PC sequencer with CALL/RET in front of an external return-address stack.
// Build macro PCSEQ_STACK_GUARD_EN adds overflow/underflow detection and FAULT.
module pcseq_call_ret
  import pcseq_pkg::*;
#(
  parameter int ADDR_WIDTH = PCSEQ_ADDR_WIDTH,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  inc,
  input  logic                  jump,
  input  logic                  call,
  input  logic                  ret,
  input  logic [ADDR_WIDTH-1:0] target,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  overflow_err,
  output logic                  underflow_err,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [ADDR_WIDTH-1:0] stk_din,
  input  logic [ADDR_WIDTH-1:0] stk_dout,
  input  logic                  stk_empty,
  input  logic                  stk_full
);

  // Stack depth is tracked by the stack itself; flags are all we need here.
  localparam int unused_depth = DEPTH;

  state_e                  state, state_n;
  logic [ADDR_WIDTH-1:0]   pc_n;
  logic [ADDR_WIDTH-1:0]   pc_inc;
  logic                    ovf_set, udf_set;
  logic                    full_q, empty_q;

  assign pc_inc  = pc + ADDR_WIDTH'(1);
  assign stk_din = pc_inc;
  assign busy    = (state != IDLE);

`ifdef PCSEQ_STACK_GUARD_EN
  assign full_q  = stk_full;
  assign empty_q = stk_empty;
`else
  // Without the guard, full/empty never block a strobe.
  logic unused_flags;
  assign unused_flags = stk_full ^ stk_empty;
  assign full_q  = 1'b0;
  assign empty_q = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    ovf_set  = 1'b0;
    udf_set  = 1'b0;
    case (state)
      IDLE: begin
        case (req_decode(call, ret, jump, inc))
          REQ_CALL: begin
            if (full_q) begin
              ovf_set = 1'b1;
              state_n = FAULT;
            end else begin
              stk_push = 1'b1;
              pc_n     = target;
            end
          end
          REQ_RET: begin
            if (empty_q) begin
              udf_set = 1'b1;
              state_n = FAULT;
            end else begin
              stk_pop = 1'b1;
              state_n = RET_WAIT;
            end
          end
          REQ_JUMP: pc_n = target;
          REQ_INC:  pc_n = pc_inc;
          default:  pc_n = pc;
        endcase
      end
      // Stack output is registered on the pop edge, so it is valid here.
      RET_WAIT: begin
        pc_n    = stk_dout;
        state_n = IDLE;
      end
`ifdef PCSEQ_STACK_GUARD_EN
      FAULT: state_n = FAULT;
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      pc    <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

`ifdef PCSEQ_STACK_GUARD_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (ovf_set) overflow_err  <= 1'b1;
      if (udf_set) underflow_err <= 1'b1;
    end
  end
`else
  logic unused_err;
  assign unused_err    = ovf_set ^ udf_set;
  assign overflow_err  = 1'b0;
  assign underflow_err = 1'b0;
`endif

endmodule
